// File: rtl/tetris_input_pkg.sv
// Shared constants for the controller input sequencer: button indices,
// repeat-capable button mask and the arbitration priority order.
package tetris_input_pkg;

    localparam int ACT_W   = 3;
    localparam int NUM_BTN = 8;

    localparam logic [ACT_W-1:0] BTN_A      = 3'd0;
    localparam logic [ACT_W-1:0] BTN_B      = 3'd1;
    localparam logic [ACT_W-1:0] BTN_SELECT = 3'd2;
    localparam logic [ACT_W-1:0] BTN_START  = 3'd3;
    localparam logic [ACT_W-1:0] BTN_RIGHT  = 3'd4;
    localparam logic [ACT_W-1:0] BTN_LEFT   = 3'd5;
    localparam logic [ACT_W-1:0] BTN_UP     = 3'd6;
    localparam logic [ACT_W-1:0] BTN_DOWN   = 3'd7;

    localparam logic [NUM_BTN-1:0] REPEAT_MASK = 8'b1011_0000;

    // Entry 0 is the highest priority.
    localparam logic [NUM_BTN-1:0][ACT_W-1:0] PRIO_ORDER = {
        BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_B,
        BTN_A, BTN_UP, BTN_SELECT, BTN_START
    };

    typedef struct packed {
        logic             found;
        logic [ACT_W-1:0] code;
    } pick_t;

    function automatic pick_t pick_pending(input logic [NUM_BTN-1:0] pend);
        pick_t p;
        p.found = 1'b0;
        p.code  = '0;
        // Walk from lowest to highest priority so the best match is written last.
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[PRIO_ORDER[i]]) begin
                p.found = 1'b1;
                p.code  = PRIO_ORDER[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tetris_input_sequencer_debounce.sv
// One button: two-flop synchroniser (resets to released), tick-based
// stability counter and the debounced pressed flop.
module btn_debounce #(
    parameter int DEB_MS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw_n,
    output logic held
);

    localparam int CW = $clog2(DEB_MS + 1);

    logic [1:0]    sync;
    logic [CW-1:0] stab_cnt;
    logic          sync_pressed;

    assign sync_pressed = ~sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], raw_n};
        end
    end

    // The counter only runs while the synchronised level disagrees with held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt <= '0;
            held     <= 1'b0;
        end else if (sync_pressed == held) begin
            stab_cnt <= '0;
        end else if (tick) begin
            if (stab_cnt == CW'(DEB_MS - 1)) begin
                held     <= ~held;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tetris_input_sequencer.sv
// Turns eight raw active-low buttons into one-at-a-time action events with
// debounce, DAS/ARR auto-repeat on Right/Left/Down and priority arbitration.
module tetris_input_sequencer
    import tetris_input_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DEB_MS   = 10,
    parameter int DAS_MS   = 170,
    parameter int ARR_MS   = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic               act_ready,
    output logic               act_valid,
    output logic [ACT_W-1:0]   act_code,
    output logic [NUM_BTN-1:0] held
);

    localparam int TW     = $clog2(TICK_DIV + 1);
    localparam int REP_MX = (DAS_MS > ARR_MS) ? DAS_MS : ARR_MS;
    localparam int RW     = $clog2(REP_MX + 1);

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] held_q;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] rep_fire;
    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] pend_set;
    logic [NUM_BTN-1:0] pend_clr;
    logic               slot_free;
    pick_t              pick;

    // tick is registered so it is high in exactly the cycle the counter reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (tick_cnt == TW'(TICK_DIV - 1));
            if (tick_cnt == TW'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_MS(DEB_MS)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw_n(btn_n[i]),
            .held (held[i])
        );

        if (REPEAT_MASK[i]) begin : g_rep
            logic [RW-1:0] rep_cnt;

            always_ff @(posedge clk) begin
                if (rst || !held[i]) begin
                    rep_cnt <= '0;
                end else if (rise[i]) begin
                    rep_cnt <= RW'(DAS_MS);
                end else if (tick && rep_cnt != '0) begin
                    if (rep_cnt == RW'(1)) begin
                        rep_cnt <= RW'(ARR_MS);
                    end else begin
                        rep_cnt <= rep_cnt - RW'(1);
                    end
                end
            end

            assign rep_fire[i] = held[i] && !rise[i] && tick && (rep_cnt == RW'(1));
        end else begin : g_norep
            assign rep_fire[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
        end else begin
            held_q <= held;
        end
    end

    assign rise      = held & ~held_q;
    assign pend_set  = rise | (rep_fire & REPEAT_MASK);
    assign pick      = pick_pending(pend);
    assign slot_free = !act_valid || act_ready;

    always_comb begin
        pend_clr = '0;
        if (slot_free && pick.found) begin
            pend_clr[pick.code] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle re-trigger stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_valid <= 1'b0;
            act_code  <= '0;
        end else if (slot_free) begin
            act_valid <= pick.found;
            if (pick.found) begin
                act_code <= pick.code;
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_sequencer.sv
// Randomised and directed bench for tetris_input_sequencer, checked every
// cycle against a tick/event-level reference model.
module tb_tetris_input_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DEB_MS   = 3;
    localparam int DAS_MS   = 5;
    localparam int ARR_MS   = 2;
    localparam logic [7:0] REP_BTNS = 8'b1011_0000;
    localparam int PRIO [8] = '{3, 2, 6, 0, 1, 7, 5, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn_n;
    logic       act_ready;
    logic       act_valid;
    logic [2:0] act_code;
    logic [7:0] held;

    tetris_input_sequencer #(
        .TICK_DIV(TICK_DIV),
        .DEB_MS  (DEB_MS),
        .DAS_MS  (DAS_MS),
        .ARR_MS  (ARR_MS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .act_ready(act_ready),
        .act_valid(act_valid),
        .act_code (act_code),
        .held     (held)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] btn_v;
    logic       ready_v;
    logic       rst_v;

    int         m_cyc;
    logic [7:0] m_b1, m_b2, m_held, m_hprev, m_pend, m_armed;
    int         m_deb [8];
    int         m_rt  [8];
    logic       m_valid;
    logic [2:0] m_code;
    int         m_xfer [8];
    int         dut_xfer [8];

    always @(posedge clk) begin
        if (rst === 1'b0 && act_valid === 1'b1 && act_ready === 1'b1) begin
            dut_xfer[act_code] = dut_xfer[act_code] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Predicts the state after the coming clock edge from the inputs about to be applied.
    task automatic modelStep();
        logic       tk, pressed, rise, found;
        logic [7:0] nheld, set, clr;
        if (rst_v) begin
            m_cyc   = 0;
            m_b1    = '1;
            m_b2    = '1;
            m_held  = '0;
            m_hprev = '0;
            m_pend  = '0;
            m_armed = '0;
            m_valid = 1'b0;
            m_code  = '0;
            for (int i = 0; i < 8; i++) begin
                m_deb[i] = 0;
                m_rt[i]  = 0;
            end
            return;
        end
        tk = (m_cyc > 0) && (m_cyc % TICK_DIV == 0);
        m_cyc++;
        if (m_valid && ready_v) m_xfer[m_code]++;
        nheld = m_held;
        set   = '0;
        clr   = '0;
        for (int i = 0; i < 8; i++) begin
            pressed = ~m_b2[i];
            if (pressed == m_held[i]) begin
                m_deb[i] = 0;
            end else if (tk) begin
                m_deb[i]++;
                if (m_deb[i] == DEB_MS) begin
                    nheld[i] = ~m_held[i];
                    m_deb[i] = 0;
                end
            end
            rise = m_held[i] & ~m_hprev[i];
            if (rise) set[i] = 1'b1;
            if (REP_BTNS[i]) begin
                if (!m_held[i]) begin
                    m_armed[i] = 1'b0;
                end else if (rise) begin
                    m_armed[i] = 1'b1;
                    m_rt[i]    = 0;
                end else if (tk && m_armed[i]) begin
                    m_rt[i]++;
                    if (m_rt[i] == DAS_MS ||
                        (m_rt[i] > DAS_MS && (m_rt[i] - DAS_MS) % ARR_MS == 0)) begin
                        set[i] = 1'b1;
                    end
                end
            end
        end
        if (!m_valid || ready_v) begin
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                if (m_pend[PRIO[k]]) begin
                    found        = 1'b1;
                    m_code       = 3'(PRIO[k]);
                    clr[PRIO[k]] = 1'b1;
                end
            end
            m_valid = found;
        end
        m_pend  = (m_pend & ~clr) | set;
        m_hprev = m_held;
        m_held  = nheld;
        m_b2    = m_b1;
        m_b1    = btn_v;
    endtask

    task automatic applyStimulus();
        btn_n     = btn_v;
        act_ready = ready_v;
        rst       = rst_v;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput("held", {24'd0, held}, {24'd0, m_held});
        checkOutput("act_valid", {31'd0, act_valid}, {31'd0, m_valid});
        if (m_valid) checkOutput("act_code", {29'd0, act_code}, {29'd0, m_code});
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic waitHeld(input int idx, input logic lvl);
        for (int k = 0; k < 100 && held[idx] !== lvl; k++) applyStimulus();
        checkOutput("wait_held", {31'd0, held[idx]}, {31'd0, lvl});
    endtask

    task automatic waitValid();
        for (int k = 0; k < 200 && act_valid !== 1'b1; k++) applyStimulus();
        checkOutput("wait_valid", {31'd0, act_valid}, 32'd1);
    endtask

    initial begin
        int   base;
        logic seen;
        for (int i = 0; i < 8; i++) begin
            m_xfer[i]   = 0;
            dut_xfer[i] = 0;
        end
        btn_v = '1; ready_v = 1'b1; rst_v = 1'b1;
        btn_n = '1; act_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        runCycles(2);
        checkOutput("rst_code", {29'd0, act_code}, 32'd0);
        rst_v = 1'b0;
        runCycles(10);

        // Clean press of A: one event only.
        base  = dut_xfer[0];
        btn_v = 8'hFE;
        waitHeld(0, 1'b1);
        runCycles(40);
        btn_v = 8'hFF;
        waitHeld(0, 1'b0);
        runCycles(20);
        checkOutput("clean_a_once", dut_xfer[0] - base, 32'd1);

        // Bouncing Start never debounces.
        base = dut_xfer[3];
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            btn_v[3] = ~btn_v[3];
            applyStimulus();
            seen |= held[3];
        end
        btn_v = 8'hFF;
        for (int n = 0; n < 30; n++) begin
            applyStimulus();
            seen |= held[3];
        end
        checkOutput("bounce_held", {31'd0, seen}, 32'd0);
        checkOutput("bounce_events", dut_xfer[3] - base, 32'd0);

        // Auto-repeat on Right.
        base  = dut_xfer[4];
        btn_v = 8'hEF;
        waitHeld(4, 1'b1);
        runCycles(15 * TICK_DIV + 2);
        btn_v = 8'hFF;
        waitHeld(4, 1'b0);
        runCycles(20);
        checkOutput("rep_min7", {31'd0, (dut_xfer[4] - base) >= 7}, 32'd1);
        base = dut_xfer[4];
        runCycles(40);
        checkOutput("rep_stop", dut_xfer[4] - base, 32'd0);

        // Arbitration under backpressure: Start, A, Left.
        ready_v = 1'b0;
        btn_v   = 8'b1101_0110;
        waitValid();
        checkOutput("arb_first", {29'd0, act_code}, 32'd3);
        runCycles(3);
        checkOutput("arb_stall_valid", {31'd0, act_valid}, 32'd1);
        checkOutput("arb_stall_code", {29'd0, act_code}, 32'd3);
        ready_v = 1'b1;
        applyStimulus();
        checkOutput("arb_second", {29'd0, act_code}, 32'd0);
        applyStimulus();
        checkOutput("arb_third", {29'd0, act_code}, 32'd5);
        applyStimulus();
        checkOutput("arb_empty", {31'd0, act_valid}, 32'd0);
        btn_v = 8'hFF;
        runCycles(60);

        // Collapse: slot held by Select while B is pressed twice.
        base    = dut_xfer[1];
        ready_v = 1'b0;
        btn_v   = 8'hFB;
        waitValid();
        checkOutput("col_select", {29'd0, act_code}, 32'd2);
        btn_v = 8'hFD;
        waitHeld(1, 1'b1);
        btn_v = 8'hFF;
        waitHeld(1, 1'b0);
        btn_v = 8'hFD;
        waitHeld(1, 1'b1);
        btn_v = 8'hFF;
        waitHeld(1, 1'b0);
        ready_v = 1'b1;
        runCycles(20);
        checkOutput("col_b_once", dut_xfer[1] - base, 32'd1);

        // Reset mid-operation with Down held through it.
        ready_v = 1'b0;
        btn_v   = 8'h7F;
        waitValid();
        checkOutput("rst_pre_code", {29'd0, act_code}, 32'd7);
        rst_v = 1'b1;
        applyStimulus();
        rst_v = 1'b0;
        checkOutput("rst_valid", {31'd0, act_valid}, 32'd0);
        checkOutput("rst_held", {24'd0, held}, 32'd0);
        checkOutput("rst_code_mid", {29'd0, act_code}, 32'd0);
        waitHeld(7, 1'b1);
        base    = dut_xfer[7];
        ready_v = 1'b1;
        runCycles(5);
        checkOutput("rst_repress", dut_xfer[7] - base, 32'd1);
        btn_v = 8'hFF;
        runCycles(60);

        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) btn_v[$urandom_range(0, 7)] ^= 1'b1;
            ready_v = ($urandom_range(0, 3) != 0);
            rst_v   = ($urandom_range(0, 999) == 0);
            applyStimulus();
        end
        rst_v   = 1'b0;
        btn_v   = 8'hFF;
        ready_v = 1'b1;
        runCycles(80);
        for (int k = 0; k < 8; k++) begin
            checkOutput("xfer_total", dut_xfer[k], m_xfer[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
